// File: rtl/writeback_merge_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : writeback_merge_unit                                         |
// | Description : Merges NUM_CH producer result streams into a single GRF      |
// |               write port. Per-channel FIFOs, round-robin drain, load       |
// |               byte/halfword extension and a registered write stage.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module writeback_merge_unit #(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4,
  localparam int OFF_W     = $clog2(DATA_W / 8)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_valid,
  output logic [NUM_CH-1:0]        ch_ready,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH*3-1:0]      ch_ext,
  input  logic [NUM_CH*OFF_W-1:0]  ch_off,
  output logic                     GRF_write_enable,
  output logic [ADDR_W-1:0]        GRF_write_addr,
  output logic [DATA_W-1:0]        GRF_write_data,
  output logic                     busy
);

  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam int c_ch_w  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int c_ent_w = 3 + OFF_W + ADDR_W + DATA_W;
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(FIFO_DEPTH);

  logic [NUM_CH-1:0]              w_push;
  logic [NUM_CH-1:0]              w_pop;
  logic [NUM_CH-1:0]              w_nonempty;
  logic [NUM_CH-1:0][c_ent_w-1:0] w_head;

  logic [c_ch_w-1:0] rr_q, rr_d;
  logic [c_ch_w-1:0] w_grant;
  logic              w_grant_vld;

  logic [c_ent_w-1:0] w_sel;
  logic [DATA_W-1:0]  w_sel_data;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [OFF_W-1:0]   w_sel_off;
  logic [2:0]         w_sel_ext;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [DATA_W-1:0]  w_ext_data;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  // Per-channel circular FIFO; entry layout is {ext, off, addr, data}.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [c_ent_w-1:0] mem_q [FIFO_DEPTH];
    logic [c_ptr_w-1:0] wr_ptr_q;
    logic [c_ptr_w-1:0] rd_ptr_q;
    logic [c_cnt_w-1:0] cnt_q;

    // Ready is taken from the registered count only, so a full FIFO
    // refuses a push even in a cycle where it is also being popped.
    assign ch_ready[i]   = (cnt_q != c_full);
    assign w_nonempty[i] = (cnt_q != '0);
    assign w_push[i]     = ch_valid[i] & ch_ready[i];
    assign w_pop[i]      = w_grant_vld && (w_grant == c_ch_w'(i));
    assign w_head[i]     = mem_q[rd_ptr_q];

    // Entry storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
      if (w_push[i]) begin
        mem_q[wr_ptr_q] <= {ch_ext[i*3 +: 3], ch_off[i*OFF_W +: OFF_W],
                            ch_addr[i*ADDR_W +: ADDR_W], ch_data[i*DATA_W +: DATA_W]};
      end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (w_push[i]) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (w_pop[i])  rd_ptr_q <= rd_ptr_q + 1'b1;
        case ({w_push[i], w_pop[i]})
          2'b10:   cnt_q <= cnt_q + 1'b1;
          2'b01:   cnt_q <= cnt_q - 1'b1;
          default: cnt_q <= cnt_q;
        endcase
      end
    end
  end

  // Round-robin search from rr_q; scanning downward lets the nearest win.
  always_comb begin
    int idx;
    w_grant_vld = 1'b0;
    w_grant     = '0;
    idx         = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = (int'(rr_q) + k) % NUM_CH;
      if (w_nonempty[idx]) begin
        w_grant_vld = 1'b1;
        w_grant     = c_ch_w'(idx);
      end
    end
    rr_d = rr_q;
    if (w_grant_vld) begin
      rr_d = (w_grant == c_ch_w'(NUM_CH - 1)) ? '0 : w_grant + 1'b1;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_q <= '0;
    else        rr_q <= rr_d;
  end

  // Unpack the granted head and apply load extension.
  always_comb begin
    w_sel      = w_head[w_grant];
    w_sel_data = w_sel[DATA_W-1:0];
    w_sel_addr = w_sel[DATA_W +: ADDR_W];
    w_sel_off  = w_sel[DATA_W+ADDR_W +: OFF_W];
    w_sel_ext  = w_sel[c_ent_w-1 -: 3];
    w_byte     = '0;
    w_half     = '0;
    for (int j = 0; j < DATA_W / 8; j++) begin
      if (w_sel_off == OFF_W'(j)) w_byte = w_sel_data[j*8 +: 8];
    end
    // Halfword index drops the offset LSB.
    for (int j = 0; j < DATA_W / 16; j++) begin
      if ((w_sel_off >> 1) == OFF_W'(j)) w_half = w_sel_data[j*16 +: 16];
    end
    case (w_sel_ext)
      3'b001:  w_ext_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
      3'b010:  w_ext_data = {{(DATA_W-8){1'b0}}, w_byte};
      3'b011:  w_ext_data = {{(DATA_W-16){w_half[15]}}, w_half};
      3'b100:  w_ext_data = {{(DATA_W-16){1'b0}}, w_half};
      default: w_ext_data = w_sel_data;
    endcase
  end

  // GRF write register; writes to register 0 are consumed silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (w_grant_vld) begin
      we_q   <= (w_sel_addr != '0);
      addr_q <= w_sel_addr;
      data_q <= w_ext_data;
    end else begin
      we_q   <= 1'b0;
    end
  end

  assign GRF_write_enable = we_q;
  assign GRF_write_addr   = addr_q;
  assign GRF_write_data   = data_q;
  assign busy             = (|w_nonempty) | we_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback_merge_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_writeback_merge_unit                                      |
// | Description : Directed self-checking bench for writeback_merge_unit.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_writeback_merge_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ch_valid;
  logic [1:0]  ch_ready;
  logic [9:0]  ch_addr;
  logic [63:0] ch_data;
  logic [5:0]  ch_ext;
  logic [3:0]  ch_off;
  logic        GRF_write_enable;
  logic [4:0]  GRF_write_addr;
  logic [31:0] GRF_write_data;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  writeback_merge_unit #(
    .NUM_CH(2), .DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(4)
  ) u_dut (
    .clk              (clk),
    .reset            (reset),
    .ch_valid         (ch_valid),
    .ch_ready         (ch_ready),
    .ch_addr          (ch_addr),
    .ch_data          (ch_data),
    .ch_ext           (ch_ext),
    .ch_off           (ch_off),
    .GRF_write_enable (GRF_write_enable),
    .GRF_write_addr   (GRF_write_addr),
    .GRF_write_data   (GRF_write_data),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push one ch0 entry, then check the data written two edges later.
  task automatic send_ext(input string tag, input logic [31:0] d,
                          input logic [2:0] e, input logic [1:0] o,
                          input logic [31:0] exp);
    ch_valid    = 2'b01;
    ch_addr[4:0] = 5'd5;
    ch_data[31:0] = d;
    ch_ext[2:0]  = e;
    ch_off[1:0]  = o;
    step();
    ch_valid = 2'b00;
    step();
    check({tag, "_we"}, {31'd0, GRF_write_enable}, 32'd1);
    check(tag, GRF_write_data, exp);
    step();
  endtask

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          exp_ch;
  int          n_wr;
  logic [1:0]  rdy_exp [8] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b10, 2'b01};

  // Compare any write against the per-channel scoreboard; channels alternate.
  task automatic check_write();
    logic [31:0] e;
    if (GRF_write_enable) begin
      n_wr++;
      check("ilv_addr", {27'd0, GRF_write_addr}, (exp_ch == 1) ? 32'd21 : 32'd7);
      if (exp_ch == 0) begin
        if (q0.size() == 0) check("ilv_underflow0", 32'd1, 32'd0);
        else begin e = q0.pop_front(); check("ilv_data0", GRF_write_data, e); end
      end else begin
        if (q1.size() == 0) check("ilv_underflow1", 32'd1, 32'd0);
        else begin e = q1.pop_front(); check("ilv_data1", GRF_write_data, e); end
      end
      exp_ch = 1 - exp_ch;
    end
  endtask

  initial begin
    logic [1:0]  acc;
    logic [31:0] seq0, seq1;
    reset    = 1'b0;
    ch_valid = '0;
    ch_addr  = '0;
    ch_data  = '0;
    ch_ext   = '0;
    ch_off   = '0;

    // Reset state
    #3;
    check("rst_we",    {31'd0, GRF_write_enable}, 32'd0);
    check("rst_addr",  {27'd0, GRF_write_addr}, 32'd0);
    check("rst_data",  GRF_write_data, 32'd0);
    check("rst_ready", {30'd0, ch_ready}, 32'd3);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Single word write: visible only in cycle N+2
    ch_valid      = 2'b01;
    ch_addr[4:0]  = 5'd8;
    ch_data[31:0] = 32'h1234_5678;
    ch_ext[2:0]   = 3'b000;
    ch_off[1:0]   = 2'd0;
    step();
    ch_valid = 2'b00;
    check("lat_n1_we",   {31'd0, GRF_write_enable}, 32'd0);
    check("lat_n1_busy", {31'd0, busy}, 32'd1);
    step();
    check("lat_n2_we",   {31'd0, GRF_write_enable}, 32'd1);
    check("lat_n2_addr", {27'd0, GRF_write_addr}, 32'd8);
    check("lat_n2_data", GRF_write_data, 32'h1234_5678);
    step();
    check("lat_n3_we",   {31'd0, GRF_write_enable}, 32'd0);
    check("lat_n3_busy", {31'd0, busy}, 32'd0);

    // Load extension
    send_ext("lb3",   32'h80FF_7F01, 3'b001, 2'd3, 32'hFFFF_FF80);
    send_ext("lbu3",  32'h80FF_7F01, 3'b010, 2'd3, 32'h0000_0080);
    send_ext("lb0",   32'h80FF_7F01, 3'b001, 2'd0, 32'h0000_0001);
    send_ext("lh1",   32'h80FF_7F01, 3'b011, 2'd1, 32'h0000_7F01);
    send_ext("lh2",   32'h80FF_7F01, 3'b011, 2'd2, 32'hFFFF_80FF);
    send_ext("lhu2",  32'h80FF_7F01, 3'b100, 2'd2, 32'h0000_80FF);
    send_ext("ext7",  32'h80FF_7F01, 3'b111, 2'd3, 32'h80FF_7F01);

    // Write to register 0 is consumed and dropped
    ch_valid      = 2'b01;
    ch_addr[4:0]  = 5'd0;
    ch_data[31:0] = 32'hDEAD_BEEF;
    ch_ext[2:0]   = 3'b000;
    step();
    ch_valid = 2'b00;
    check("r0_busy_q", {31'd0, busy}, 32'd1);
    step();
    check("r0_we",   {31'd0, GRF_write_enable}, 32'd0);
    check("r0_busy", {31'd0, busy}, 32'd0);

    // Reset mid-stream with three entries queued
    ch_valid = 2'b11;
    ch_addr  = {5'd4, 5'd3};
    ch_data  = {32'h1111_1111, 32'h2222_2222};
    ch_ext   = '0;
    step();
    step();
    ch_valid = 2'b00;
    check("prerst_we", {31'd0, GRF_write_enable}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mrst_we",    {31'd0, GRF_write_enable}, 32'd0);
    check("mrst_addr",  {27'd0, GRF_write_addr}, 32'd0);
    check("mrst_data",  GRF_write_data, 32'd0);
    check("mrst_ready", {30'd0, ch_ready}, 32'd3);
    check("mrst_busy",  {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("post_rst_we",   {31'd0, GRF_write_enable}, 32'd0);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
    end

    // Both channels push every cycle; ready pattern and order are checked
    exp_ch = 0;
    n_wr   = 0;
    seq0   = 0;
    seq1   = 0;
    ch_addr = {5'd21, 5'd7};
    ch_ext  = '0;
    ch_off  = '0;
    for (int c = 0; c < 8; c++) begin
      ch_valid = 2'b11;
      ch_data  = {32'hB000_0000 + seq1, 32'hA000_0000 + seq0};
      acc      = ch_ready;
      step();
      if (acc[0]) begin q0.push_back(32'hA000_0000 + seq0); seq0++; end
      if (acc[1]) begin q1.push_back(32'hB000_0000 + seq1); seq1++; end
      check("ilv_ready", {30'd0, ch_ready}, {30'd0, rdy_exp[c]});
      check_write();
    end
    ch_valid = 2'b00;
    for (int c = 0; c < 40; c++) begin
      if (!busy) break;
      step();
      check_write();
    end
    check("ilv_nwr",   n_wr, 32'd14);
    check("ilv_q0",    q0.size(), 32'd0);
    check("ilv_q1",    q1.size(), 32'd0);
    check("ilv_busy",  {31'd0, busy}, 32'd0);
    check("ilv_ready_end", {30'd0, ch_ready}, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
